// File: rtl/data_cache_pkg.sv
// Shared constants and FSM state type for the direct-mapped write-back data cache.
package data_cache_pkg;

    localparam int unsigned LINE_BYTES     = 16;
    localparam int unsigned NUM_SETS       = 16;
    localparam int unsigned OFFSET_W       = $clog2(LINE_BYTES);
    localparam int unsigned INDEX_W        = $clog2(NUM_SETS);
    localparam int unsigned TAG_W          = 32 - OFFSET_W - INDEX_W;
    localparam int unsigned WORDS_PER_LINE = LINE_BYTES / 4;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteback,
        StAllocate,
        StFillWait
    } cache_state_e;

endpackage

// File: rtl/data_cache_if.sv
// CPU request/response and backing-memory handshake bundle for data_cache.
interface data_cache_if #(
    parameter int unsigned LINE_BYTES = data_cache_pkg::LINE_BYTES
);
    logic                    is_input_valid;
    logic [31:0]             addr;
    logic                    mem_read;
    logic                    mem_write;
    logic [31:0]             din;
    logic                    is_ready;
    logic                    is_output_valid;
    logic [31:0]             dout;
    logic                    is_hit;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_req_write;
    logic [31:0]             mem_req_addr;
    logic [LINE_BYTES*8-1:0] mem_req_wdata;
    logic                    mem_resp_valid;
    logic [LINE_BYTES*8-1:0] mem_resp_rdata;

    // Cache side.
    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output is_ready, is_output_valid, dout, is_hit,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
    );

    // CPU plus backing-memory side.
    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  is_ready, is_output_valid, dout, is_hit,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
    );

endinterface

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage: combinational read by index, one synchronous write port
// that either updates a single word (marking the line dirty) or installs a whole clean line.
module cache_line_array #(
    parameter int unsigned LINE_BYTES = data_cache_pkg::LINE_BYTES,
    parameter int unsigned NUM_SETS   = data_cache_pkg::NUM_SETS,
    localparam int unsigned LineW     = LINE_BYTES * 8,
    localparam int unsigned OffW      = $clog2(LINE_BYTES),
    localparam int unsigned IdxW      = $clog2(NUM_SETS),
    localparam int unsigned TagW      = 32 - OffW - IdxW,
    localparam int unsigned WordW     = OffW - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IdxW-1:0]  rd_index_i,
    output logic             rd_valid_o,
    output logic             rd_dirty_o,
    output logic [TagW-1:0]  rd_tag_o,
    output logic [LineW-1:0] rd_data_o,
    input  logic             wr_word_en_i,
    input  logic             wr_line_en_i,
    input  logic [IdxW-1:0]  wr_index_i,
    input  logic [WordW-1:0] wr_word_sel_i,
    input  logic [31:0]      wr_word_i,
    input  logic [TagW-1:0]  wr_tag_i,
    input  logic [LineW-1:0] wr_line_i
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TagW-1:0]     tag_q  [NUM_SETS];
    logic [LineW-1:0]    data_q [NUM_SETS];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_line_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
            dirty_q[wr_index_i] <= 1'b0;
        end else if (wr_word_en_i) begin
            dirty_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (wr_line_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_line_i;
        end else if (wr_word_en_i) begin
            data_q[wr_index_i][32*wr_word_sel_i +: 32] <= wr_word_i;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: request FSM, hit/miss statistics
// and the line-granular backing-memory handshake.
module data_cache #(
    parameter int unsigned LINE_BYTES = data_cache_pkg::LINE_BYTES,
    parameter int unsigned NUM_SETS   = data_cache_pkg::NUM_SETS
) (
    input  logic         clk,
    input  logic         reset,
    data_cache_if.slave  bus,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    import data_cache_pkg::*;

    localparam int unsigned LineW = LINE_BYTES * 8;
    localparam int unsigned OffW  = $clog2(LINE_BYTES);
    localparam int unsigned IdxW  = $clog2(NUM_SETS);
    localparam int unsigned TagW  = 32 - OffW - IdxW;
    localparam int unsigned WordW = OffW - 2;

    cache_state_e state_q, state_d;
    logic [31:0]  addr_q;
    logic [31:0]  din_q;
    logic         write_q;
    logic         first_q;
    logic [31:0]  hit_count_q;
    logic [31:0]  miss_count_q;

    logic [IdxW-1:0]  req_index;
    logic [TagW-1:0]  req_tag;
    logic [WordW-1:0] req_word;
    logic             rd_valid, rd_dirty, hit;
    logic [TagW-1:0]  rd_tag;
    logic [LineW-1:0] rd_data;
    logic             wr_word_en, wr_line_en;
    logic             accept;

    assign req_index = addr_q[OffW +: IdxW];
    assign req_tag   = addr_q[31 -: TagW];
    assign req_word  = addr_q[2 +: WordW];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign accept    = bus.is_input_valid && (state_q == StIdle);

    cache_line_array #(
        .LINE_BYTES (LINE_BYTES),
        .NUM_SETS   (NUM_SETS)
    ) u_lines (
        .clk           (clk),
        .reset         (reset),
        .rd_index_i    (req_index),
        .rd_valid_o    (rd_valid),
        .rd_dirty_o    (rd_dirty),
        .rd_tag_o      (rd_tag),
        .rd_data_o     (rd_data),
        .wr_word_en_i  (wr_word_en),
        .wr_line_en_i  (wr_line_en),
        .wr_index_i    (req_index),
        .wr_word_sel_i (req_word),
        .wr_word_i     (din_q),
        .wr_tag_i      (req_tag),
        .wr_line_i     (bus.mem_resp_rdata)
    );

    always_comb begin
        state_d             = state_q;
        bus.is_ready        = 1'b0;
        bus.is_output_valid = 1'b0;
        bus.dout            = '0;
        bus.is_hit          = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_write   = 1'b0;
        bus.mem_req_addr    = '0;
        bus.mem_req_wdata   = '0;
        wr_word_en          = 1'b0;
        wr_line_en          = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.is_ready = 1'b1;
                if (bus.is_input_valid) state_d = StCompare;
            end
            StCompare: begin
                if (hit) begin
                    bus.is_output_valid = 1'b1;
                    bus.is_hit          = first_q;
                    bus.dout            = write_q ? 32'h0 : rd_data[32*req_word +: 32];
                    wr_word_en          = write_q;
                    state_d             = StIdle;
                end else begin
                    state_d = (rd_valid && rd_dirty) ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                // Array is untouched in this state, so victim fields hold stable.
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = 1'b1;
                bus.mem_req_addr  = {rd_tag, req_index, {OffW{1'b0}}};
                bus.mem_req_wdata = rd_data;
                if (bus.mem_req_ready) state_d = StAllocate;
            end
            StAllocate: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {req_tag, req_index, {OffW{1'b0}}};
                if (bus.mem_req_ready) state_d = StFillWait;
            end
            StFillWait: begin
                if (bus.mem_resp_valid) begin
                    wr_line_en = 1'b1;
                    state_d    = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset abandons any transaction: no completion and no array update.
        if (!reset) begin
            state_d             = StIdle;
            bus.is_output_valid = 1'b0;
            bus.is_hit          = 1'b0;
            bus.dout            = '0;
            bus.mem_req_valid   = 1'b0;
            wr_word_en          = 1'b0;
            wr_line_en          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            first_q      <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                first_q <= 1'b1;
            end else if (state_q == StCompare) begin
                first_q <= 1'b0;
            end
            // Only the first lookup of an access is counted; re-compares after a fill are not.
            if (state_q == StCompare && first_q) begin
                if (hit) hit_count_q  <= hit_count_q + 32'd1;
                else     miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addr;
            din_q   <= bus.din;
            write_q <= bus.mem_write;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters: LINE_BYTES, default 16, bytes per line; NUM_SETS, default 16, direct-mapped sets.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low (0 = reset).
REQ-004 is_input_valid  input  1  CPU request strobe.
REQ-005 addr  input  32  byte address, word-aligned.
REQ-006 mem_read / mem_write  input  1 each  access type; both high is treated as a write.
REQ-007 din  input  32  store data.
REQ-008 is_ready  output  1  cache accepts a request this cycle.
REQ-009 is_output_valid  output  1  one-cycle completion pulse.
REQ-010 dout  output  32  load data; valid only while is_output_valid is high.
REQ-011 is_hit  output  1  the completed access hit on its first lookup.
REQ-012 mem_req_valid / mem_req_ready  output / input  1 each  backing-memory request handshake.
REQ-013 mem_req_write  output  1  1 = line writeback, 0 = line fill.
REQ-014 mem_req_addr  output  32  line-aligned address.
REQ-015 mem_req_wdata  output  LINE_BYTES*8  writeback line.
REQ-016 mem_resp_valid / mem_resp_rdata  input  1 / LINE_BYTES*8  fill data return.
REQ-017 hit_count / miss_count  output  32 each  access statistics.

Function
REQ-018 Address fields: offset = addr[3:0] (word select addr[3:2]), index = addr[7:4], tag = addr[31:8]. Field widths follow the parameters.
REQ-019 Write policy: write-back with write-allocate. Each line holds valid, dirty, tag and data.
REQ-020 FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL_WAIT.
REQ-021 is_ready = 1 only in IDLE. A request is accepted when is_input_valid && is_ready; addr, din and type are latched and the FSM moves to COMPARE.
REQ-022 COMPARE on a hit:
  - is_output_valid = 1 in this cycle, so hit latency is 1 cycle after acceptance;
  - a read drives dout with the selected word;
  - a write updates that word and sets dirty;
  - next state is IDLE.
REQ-023 COMPARE on a miss: go to WRITEBACK if the victim line is valid && dirty, otherwise go to ALLOCATE.
REQ-024 WRITEBACK:
  - drive mem_req_valid=1, mem_req_write=1, addr={victim tag, index, 0}, wdata = victim line;
  - hold all fields stable until mem_req_ready;
  - on the handshake, go to ALLOCATE.
REQ-025 ALLOCATE: drive mem_req_valid=1, mem_req_write=0, addr = line-aligned request address; hold until mem_req_ready, then go to FILL_WAIT.
REQ-026 FILL_WAIT: on mem_resp_valid, install the line with valid=1, dirty=0 and the new tag, then return to COMPARE. The re-compare hits and completes per REQ-022.
REQ-027 is_hit = 1 only if the first COMPARE of the access hit. It is sampled with is_output_valid.
REQ-028 Counters:
  - hit_count increments once per access whose first COMPARE hits;
  - miss_count increments once per access whose first COMPARE misses;
  - re-compares are never counted;
  - both counters wrap modulo 2^32.
REQ-029 Ignored inputs: mem_resp_valid outside FILL_WAIT, and is_input_valid outside IDLE.
REQ-030 mem_req_valid = 0 in IDLE, COMPARE and FILL_WAIT.
REQ-031 A mem_req_ready that arrives in the same cycle mem_req_valid first rises completes the handshake in that cycle.

Reset
REQ-032 While reset=0 at a rising edge:
  - FSM goes to IDLE;
  - all valid and dirty bits clear;
  - hit_count and miss_count clear;
  - is_output_valid, is_hit and mem_req_valid go to 0;
  - dout goes to 0.
REQ-033 Reset mid-transaction abandons it: no fill is installed and no completion pulse is issued. is_ready = 1 on the first cycle after reset deasserts.
REQ-034 Tag and data arrays need not be cleared on reset.

Structure
REQ-035 A shared package holds the FSM state enum, LINE_BYTES, NUM_SETS, and the derived OFFSET_W / INDEX_W / TAG_W constants.
REQ-036 One sub-module, cache_line_array, holds tag/valid/dirty/data storage:
  - combinational read by index;
  - one synchronous write port supporting word-write and full-line write.
REQ-037 The FSM, counters and memory handshake live in data_cache.

Verification
REQ-038 Cold read: reset, then read 0x0000_0040.
  - Expect miss; no WRITEBACK; ALLOCATE addr=0x40; fill returns word0=0x1111_1111.
  - Expect dout=0x1111_1111, is_hit=0, miss_count=1.
REQ-039 Hit pair: write 0xDEAD_BEEF to 0x44, then read 0x44.
  - Expect both hit with completion 1 cycle after acceptance.
  - Expect dout=0xDEAD_BEEF and hit_count=2.
REQ-040 Dirty eviction: after REQ-039, read 0x0000_0144 (same index, new tag).
  - Expect WRITEBACK addr=0x40 with word1=0xDEAD_BEEF, then ALLOCATE addr=0x140.
REQ-041 Backpressure: hold mem_req_ready=0 for 5 cycles during ALLOCATE.
  - Expect mem_req_valid and addr stable throughout; is_ready=0; no completion pulse.
REQ-042 Reset in FILL_WAIT: assert reset, then deliver mem_resp_valid.
  - Expect no install; the next read of the same address misses.
  - Expect is_ready=1 one cycle after reset release.
REQ-043 Counter wrap: force hit_count=0xFFFF_FFFF, then perform one hit.
  - Expect hit_count=0.
